// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int WS_CNT_WIDTH = 4;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Why an access was rejected, for assertions and coverage.
  typedef enum logic [1:0] {
    ALIGN    = 2'd0,
    RANGE    = 2'd1,
    CONFLICT = 2'd2
  } err_cause_t;

  // One load/store request as seen by the controller.
  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised single-port RAM: synchronous write, combinational read.
// The controller registers the read word itself, so the read is left open.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory stage: wait-state FSM in front of a word RAM, with one-cycle
// ready/error completion pulses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_write_data,
  output logic [DATA_WIDTH-1:0] dmem_read_data,
  output logic                  dmem_ready,
  output logic                  dmem_error,
  output logic                  dmem_busy
);

  state_t                  state, state_nxt;
  logic [WS_CNT_WIDTH-1:0] cnt, cnt_nxt;
  req_t                    req_q, cur;
  logic                    cur_err, err_q, access, ram_we;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  // In IDLE the live inputs are the request being accepted (this matters when
  // WAIT_STATES is 0 and the access happens on the acceptance edge); after
  // that only the latched copy is used, so the core may drop its request.
  always_comb begin
    cur = req_q;
    if (state == IDLE) cur = '{rd: mem_read, wr: mem_write,
                               addr: dmem_addr, wdata: dmem_write_data};
  end

  // Illegal: misaligned, beyond the RAM, or read and write together.
  assign cur_err = (|cur.addr[1:0])
                 | (|(cur.addr >> (ADDR_WIDTH + 2)))
                 | (cur.rd & cur.wr);

  // Next-state and wait counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mem_read | mem_write) begin
          if (WAIT_STATES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WS_CNT_WIDTH'(WAIT_STATES - 1);
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The RAM access is performed on the edge that enters RESP.
  assign access = (state_nxt == RESP);
  assign ram_we = access & cur.wr & ~cur_err;

  // State and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request latch, loaded only when a request is accepted in IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                       req_q <= '0;
    else if (state == IDLE && (mem_read | mem_write)) req_q <= cur;
  end

  // Response registers: error flag for RESP, load data held until next load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q          <= 1'b0;
      dmem_read_data <= '0;
    end else if (access) begin
      err_q <= cur_err;
      if (cur.rd & ~cur_err) dmem_read_data <= ram_rdata;
    end
  end

  assign dmem_ready = (state == RESP);
  assign dmem_error = (state == RESP) & err_q;
  assign dmem_busy  = (state != IDLE);

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clock (clock),
    .we    (ram_we),
    .addr  (cur.addr[ADDR_WIDTH+1:2]),
    .wdata (cur.wdata),
    .rdata (ram_rdata)
  );

  // An error is only ever reported as part of a completion.
  a_err_with_ready: assert property (@(posedge clock) disable iff (reset)
                                     dmem_error |-> dmem_ready);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one instance with two wait states, one with none.
// Drivers queue the expected completion; a negedge monitor checks each ready.
module tb_dmem_ctrl;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          acc;
  } exp_t;

  logic        clock = 1'b0;
  logic        rst   [2];
  logic        mrd   [2];
  logic        mwr   [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [31:0] rdat  [2];
  logic        rdy   [2];
  logic        err   [2];
  logic        busy  [2];

  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   in_resp [2];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_ctrl #(.ADDR_WIDTH(8), .WAIT_STATES(2)) u_ws2 (
    .clock(clock), .reset(rst[0]), .mem_read(mrd[0]), .mem_write(mwr[0]),
    .dmem_addr(addr[0]), .dmem_write_data(wd[0]), .dmem_read_data(rdat[0]),
    .dmem_ready(rdy[0]), .dmem_error(err[0]), .dmem_busy(busy[0]));

  dmem_ctrl #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
    .clock(clock), .reset(rst[1]), .mem_read(mrd[1]), .mem_write(mwr[1]),
    .dmem_addr(addr[1]), .dmem_write_data(wd[1]), .dmem_read_data(rdat[1]),
    .dmem_ready(rdy[1]), .dmem_error(err[1]), .dmem_busy(busy[1]));

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (rdy[0]) begin
      if (q0.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL ws2_unexpected_ready: got ready with empty queue, expected none");
      end else begin
        e = q0.pop_front();
        chk("ws2_error",   32'(err[0]), 32'(e.err));
        chk("ws2_rdata",   rdat[0], e.rd);
        chk("ws2_latency", 32'(cyc - e.acc), 32'd2);
      end
    end
    if (rdy[1]) begin
      if (q1.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL ws0_unexpected_ready: got ready with empty queue, expected none");
      end else begin
        e = q1.pop_front();
        chk("ws0_error",   32'(err[1]), 32'(e.err));
        chk("ws0_rdata",   rdat[1], e.rd);
        chk("ws0_latency", 32'(cyc - e.acc), 32'd0);
      end
    end
  end

  // One transfer: start at a negedge, hold until ready (or drop early).
  task automatic xfer(input int d, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] data,
                      input logic e, input logic [31:0] rd_exp, input bit drop);
    exp_t x;
    bit   seen;
    x.err = e;
    x.rd  = rd_exp;
    x.acc = cyc + 1 + int'(in_resp[d]);
    if (d == 0) q0.push_back(x); else q1.push_back(x);
    mrd[d] = r; mwr[d] = w; addr[d] = a; wd[d] = data;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clock);
      if (k == 1 + int'(in_resp[d])) begin
        chk($sformatf("busy_after_accept_dut%0d", d), 32'(busy[d]), 32'd1);
        if (drop) begin mrd[d] = 1'b0; mwr[d] = 1'b0; end
      end
      if (rdy[d]) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout_dut%0d: got no ready in 40 cycles, expected ready", d);
    end
    mrd[d] = 1'b0; mwr[d] = 1'b0;
    in_resp[d] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
    in_resp[0] = 1'b0;
    in_resp[1] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; mrd[d] = 1'b0; mwr[d] = 1'b0;
      addr[d] = '0;  wd[d] = '0;    in_resp[d] = 1'b0;
    end
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_rdata_dut%0d", d), rdat[d], 32'h0);
      chk($sformatf("reset_ready_dut%0d", d), 32'(rdy[d]), 32'd0);
      chk($sformatf("reset_error_dut%0d", d), 32'(err[d]), 32'd0);
      chk($sformatf("reset_busy_dut%0d", d),  32'(busy[d]), 32'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    idle(2);

    // Two wait states: store/load, misaligned, range, conflict, boundary.
    //   d  rd  wr  addr           wdata          err  rdata expected      drop
    xfer(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0);
    xfer(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0);
    xfer(0, 1'b0, 1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF, 1'b0);
    xfer(0, 1'b1, 1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0);
    xfer(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h1111_1111, 1'b0);
    xfer(0, 1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 32'h1111_1111, 1'b0);
    xfer(0, 1'b0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 1'b1, 32'h1111_1111, 1'b0);
    xfer(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_A5A5, 1'b0);
    xfer(0, 1'b1, 1'b1, 32'h0000_0000, 32'h0,         1'b1, 32'hA5A5_A5A5, 1'b0);
    xfer(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_A5A5, 1'b0);
    xfer(0, 1'b1, 1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'hA5A5_A5A5, 1'b0);
    xfer(0, 1'b0, 1'b1, 32'h0000_03FC, 32'h600D_F00D, 1'b0, 32'hA5A5_A5A5, 1'b0);
    xfer(0, 1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h600D_F00D, 1'b0);
    // Request dropped one cycle after acceptance still completes.
    xfer(0, 1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 32'h600D_F00D, 1'b1);
    xfer(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b0);
    xfer(0, 1'b0, 1'b1, 32'h0000_0030, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 1'b0);
    idle(2);

    // Reset in the middle of WAIT aborts the write and clears outputs at once.
    mwr[0] = 1'b1; addr[0] = 32'h0000_0030; wd[0] = 32'h1234_5678;
    @(posedge clock);
    #2 rst[0] = 1'b1;
    #1;
    chk("midwait_reset_ready", 32'(rdy[0]),  32'd0);
    chk("midwait_reset_error", 32'(err[0]),  32'd0);
    chk("midwait_reset_busy",  32'(busy[0]), 32'd0);
    chk("midwait_reset_rdata", rdat[0],      32'h0);
    mwr[0] = 1'b0;
    @(negedge clock);
    rst[0] = 1'b0;
    idle(2);
    xfer(0, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 1'b0, 32'h0000_0000, 1'b0);
    xfer(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0);
    idle(2);

    // No wait states, back-to-back transfers.
    xfer(1, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0005, 1'b0, 32'h0, 1'b0);
    xfer(1, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_0006, 1'b0, 32'h0, 1'b0);
    xfer(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h5, 1'b0);
    xfer(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h6, 1'b0);
    xfer(1, 1'b1, 1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h6, 1'b0);
    idle(3);

    chk("ws2_queue_drained", 32'(q0.size()), 32'd0);
    chk("ws0_queue_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
